// File: rtl/spi_stream_bridge.sv
// Flow-controlled bridge between an on-chip word producer and the SPI_Slave core:
// a TX FIFO popped on each SPI transfer start, plus a latched RX word path.
module spi_stream_bridge #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DEPTH       = 16,
  parameter int                    SYNC_STAGES = 3,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_valid,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_full,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  input  logic                         spi_busy,
  output logic [DATA_WIDTH-1:0]        spi_data_in,
  output logic                         spi_data_in_valid,
  input  logic [DATA_WIDTH-1:0]        spi_data_out,
  input  logic                         spi_data_out_valid,
  output logic [DATA_WIDTH-1:0]        rx_data,
  output logic                         rx_valid,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [SYNC_STAGES-1:0] sync;

  logic busy_rise;
  logic fifo_empty;
  logic pop_fifo;
  logic push_ok;

  assign busy_rise  = !sync[SYNC_STAGES-1] && sync[SYNC_STAGES-2];
  assign fifo_empty = (level == '0);
  assign wr_full    = (level == FULL_LEVEL);
  assign pop_fifo   = busy_rise && !fifo_empty;
  assign push_ok    = wr_valid && (!wr_full || pop_fifo);

  // Memory has no reset; writes are suppressed during rst and clear.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push_ok) begin
      mem[wptr] <= wr_data;
    end
  end

  // The chain resets to all ones so that a spi_busy still high from an
  // interrupted transfer cannot look like a fresh rising edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync              <= '1;
      wptr              <= '0;
      rptr              <= '0;
      level             <= '0;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
      spi_data_in       <= FILL_WORD;
      spi_data_in_valid <= 1'b0;
      rx_data           <= '0;
      rx_valid          <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], spi_busy};

      if (clear) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= spi_data_out_valid;
        if (spi_data_out_valid) begin
          rx_data <= spi_data_out;
        end
      end

      if (clear) begin
        wptr              <= '0;
        rptr              <= '0;
        level             <= '0;
        overflow          <= 1'b0;
        underflow         <= 1'b0;
        spi_data_in_valid <= 1'b0;
      end else begin
        spi_data_in_valid <= busy_rise;
        if (push_ok) begin
          wptr <= wptr + 1'b1;
        end else if (wr_valid) begin
          overflow <= 1'b1;
        end
        if (busy_rise) begin
          if (fifo_empty) begin
            spi_data_in <= FILL_WORD;
            underflow   <= 1'b1;
          end else begin
            spi_data_in <= mem[rptr];
            rptr        <= rptr + 1'b1;
          end
        end
        level <= level + {{(LW-1){1'b0}}, push_ok} - {{(LW-1){1'b0}}, pop_fifo};
      end
    end
  end

endmodule

// File: tb/tb_spi_stream_bridge.sv
// Directed self-checking bench for spi_stream_bridge: table-driven push checks
// plus hand-written pop, underflow, clear and reset-during-transfer sequences.
module tb_spi_stream_bridge;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int SYNC  = 3;
  localparam logic [DW-1:0] FILL = 8'h00;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_full;
  logic [4:0]    level;
  logic          spi_busy = 1'b0;
  logic [DW-1:0] spi_data_in;
  logic          spi_data_in_valid;
  logic [DW-1:0] spi_data_out = '0;
  logic          spi_data_out_valid = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          overflow;
  logic          underflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            exp_level;
    logic          exp_full;
    logic          exp_overflow;
  } push_vec_t;

  push_vec_t stream_tab [4];
  push_vec_t full_tab   [17];

  spi_stream_bridge #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .SYNC_STAGES(SYNC),
    .FILL_WORD  (FILL)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .clear             (clear),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .wr_full           (wr_full),
    .level             (level),
    .spi_busy          (spi_busy),
    .spi_data_in       (spi_data_in),
    .spi_data_in_valid (spi_data_in_valid),
    .spi_data_out      (spi_data_out),
    .spi_data_out_valid(spi_data_out_valid),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; everything is driven and sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Push one word and check the registered status against the table record.
  task automatic applyStimulus(input push_vec_t v, input string name);
    wr_valid = 1'b1;
    wr_data  = v.data;
    tick();
    wr_valid = 1'b0;
    checkOutput({name, " level"}, 32'(level), 32'(v.exp_level));
    checkOutput({name, " wr_full"}, 32'(wr_full), 32'(v.exp_full));
    checkOutput({name, " overflow"}, 32'(overflow), 32'(v.exp_overflow));
  endtask

  // One spi_busy pulse. The rise reaches sync[1] after two edges, so the load
  // strobe appears right after the third edge; an optional push is presented
  // on exactly that popping edge.
  task automatic popWord(input logic do_push, input logic [DW-1:0] push_data,
                         input logic [DW-1:0] exp_data, input string name);
    int early;
    early = 0;
    spi_busy = 1'b1;
    repeat (SYNC - 1) begin
      tick();
      if (spi_data_in_valid) early++;
    end
    if (do_push) begin
      wr_valid = 1'b1;
      wr_data  = push_data;
    end
    tick();
    wr_valid = 1'b0;
    spi_busy = 1'b0;
    checkOutput({name, " early strobe"}, 32'(early), 32'd0);
    checkOutput({name, " strobe"}, 32'(spi_data_in_valid), 32'd1);
    checkOutput({name, " data"}, 32'(spi_data_in), 32'(exp_data));
    tick();
    checkOutput({name, " strobe width"}, 32'(spi_data_in_valid), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int stray;
    push_vec_t v;

    for (int i = 0; i < 4; i++) begin
      stream_tab[i] = '{8'hA0 + 8'(i), i + 1, 1'b0, 1'b0};
    end
    for (int i = 0; i < 17; i++) begin
      full_tab[i] = '{8'(i), (i < 16) ? i + 1 : 16, (i >= 15), (i == 16)};
    end

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset spi_data_in", 32'(spi_data_in), 32'(FILL));
    checkOutput("reset spi_data_in_valid", 32'(spi_data_in_valid), 32'd0);
    checkOutput("reset rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset wr_full", 32'(wr_full), 32'd0);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset underflow", 32'(underflow), 32'd0);

    // Stream order
    for (int i = 0; i < 4; i++) applyStimulus(stream_tab[i], $sformatf("stream push %0d", i));
    for (int i = 0; i < 4; i++) popWord(1'b0, '0, 8'hA0 + 8'(i), $sformatf("stream pop %0d", i));
    checkOutput("stream final level", 32'(level), 32'd0);
    checkOutput("stream underflow", 32'(underflow), 32'd0);

    // Full, overflow and pointer wrap (pointers start at 4 here)
    for (int i = 0; i < 17; i++) applyStimulus(full_tab[i], $sformatf("full push %0d", i));
    for (int i = 0; i < 16; i++) begin
      popWord(1'b0, '0, 8'(i), $sformatf("wrap pop %0d", i));
      checkOutput($sformatf("wrap level %0d", i), 32'(level), 32'(15 - i));
    end
    checkOutput("wrap overflow sticky", 32'(overflow), 32'd1);
    checkOutput("wrap underflow", 32'(underflow), 32'd0);

    // Underflow with a simultaneous push into the empty FIFO
    popWord(1'b1, 8'h55, FILL, "underflow pop");
    checkOutput("underflow flag", 32'(underflow), 32'd1);
    checkOutput("underflow level", 32'(level), 32'd1);
    popWord(1'b0, '0, 8'h55, "underflow follow pop");
    checkOutput("underflow follow level", 32'(level), 32'd0);

    // Full FIFO with push and pop on the same edge
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = '{8'hB0 + 8'(i), i + 1, (i == 15), 1'b0};
      applyStimulus(v, $sformatf("refill push %0d", i));
    end
    popWord(1'b1, 8'h77, 8'hB0, "full push+pop");
    checkOutput("full push+pop level", 32'(level), 32'd16);
    checkOutput("full push+pop overflow", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) popWord(1'b0, '0, 8'hB0 + 8'(i), $sformatf("drain pop %0d", i));
    popWord(1'b0, '0, 8'h77, "pushed word pop");
    checkOutput("drain level", 32'(level), 32'd0);

    // RX path
    spi_data_out       = 8'h3C;
    spi_data_out_valid = 1'b1;
    tick();
    spi_data_out_valid = 1'b0;
    spi_data_out       = 8'hFF;
    checkOutput("rx_valid strobe", 32'(rx_valid), 32'd1);
    checkOutput("rx_data", 32'(rx_data), 32'h3C);
    tick();
    checkOutput("rx_valid width", 32'(rx_valid), 32'd0);
    checkOutput("rx_data hold", 32'(rx_data), 32'h3C);

    // Clear with level 5 and overflow set
    for (int i = 0; i < 17; i++) begin
      v = '{8'hE0 + 8'(i), (i < 16) ? i + 1 : 16, (i >= 15), (i == 16)};
      applyStimulus(v, $sformatf("preclear push %0d", i));
    end
    for (int i = 0; i < 11; i++) popWord(1'b0, '0, 8'hE0 + 8'(i), $sformatf("preclear pop %0d", i));
    checkOutput("preclear level", 32'(level), 32'd5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clear level", 32'(level), 32'd0);
    checkOutput("clear overflow", 32'(overflow), 32'd0);
    checkOutput("clear underflow", 32'(underflow), 32'd0);
    checkOutput("clear wr_full", 32'(wr_full), 32'd0);
    checkOutput("clear rx_data kept", 32'(rx_data), 32'h3C);
    checkOutput("clear spi_data_in kept", 32'(spi_data_in), 32'hEA);

    // Reset in the middle of a transfer: busy stays high and must not load
    v = '{8'hC5, 1, 1'b0, 1'b0};
    applyStimulus(v, "midreset push");
    spi_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    stray = 0;
    repeat (8) begin
      tick();
      if (spi_data_in_valid) stray++;
    end
    checkOutput("midreset no load", 32'(stray), 32'd0);
    checkOutput("midreset level", 32'(level), 32'd0);
    checkOutput("midreset spi_data_in", 32'(spi_data_in), 32'(FILL));
    spi_busy = 1'b0;
    repeat (SYNC) tick();
    v = '{8'hD1, 1, 1'b0, 1'b0};
    applyStimulus(v, "postreset push");
    popWord(1'b0, '0, 8'hD1, "postreset pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
